// File: rtl/obi_cache_regif.sv
// OBI slave register front-end for the key/value cache controller.
// Staged KEY/VALUE operands, CMD launch, RESULT/STATUS readback and a completion timeout.
module obi_cache_regif #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int KEY_W   = 32,
    parameter int VALUE_W = 64,
    parameter int OP_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [ADDR_W-1:0]     obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [DATA_W/8-1:0]   obi_be_i,
    input  logic [DATA_W-1:0]     obi_wdata_i,
    output logic                  obi_rvalid_o,
    input  logic                  obi_rready_i,
    output logic [DATA_W-1:0]     obi_rdata_o,
    output logic                  obi_err_o,
    output logic [OP_W-1:0]       op_o,
    output logic [KEY_W-1:0]      key_o,
    output logic [VALUE_W-1:0]    value_o,
    input  logic                  ctrl_ready_i,
    input  logic                  ctrl_succ_i,
    input  logic [VALUE_W-1:0]    ctrl_value_i,
    output logic                  done_o
);

    localparam int BE_W = DATA_W / 8;
    localparam int AL   = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int WI   = ADDR_W - AL;
    localparam int VW   = (VALUE_W + DATA_W - 1) / DATA_W;
    localparam int KW   = (KEY_W + DATA_W - 1) / DATA_W;
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WI-1:0] A_KEY  = WI'(VW);
    localparam logic [WI-1:0] A_CMD  = WI'(VW + KW);
    localparam logic [WI-1:0] A_STAT = WI'(VW + KW + 1);
    localparam logic [WI-1:0] A_RES  = WI'(VW + KW + 2);
    localparam logic [WI-1:0] A_END  = WI'(VW + KW + 2 + VW);

    localparam logic [VW*DATA_W-1:0] VMASK = {VALUE_W{1'b1}};
    localparam logic [KW*DATA_W-1:0] KMASK = {KEY_W{1'b1}};

    typedef enum logic {C_IDLE, C_BUSY} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [VW*DATA_W-1:0]   r_value;
    logic [KW*DATA_W-1:0]   r_key;
    logic [VW*DATA_W-1:0]   r_result;
    logic [OP_W-1:0]        r_op;
    logic [CW-1:0]          r_cnt;
    logic                   r_done;
    logic                   r_err;
    logic                   r_tmo;
    logic                   r_rvalid;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_rerr;

    logic [WI-1:0]          w_widx;
    logic                   w_busy;
    logic                   w_sel_val;
    logic                   w_sel_key;
    logic                   w_sel_cmd;
    logic                   w_sel_stat;
    logic                   w_sel_res;
    logic                   w_mapped;
    logic                   w_rsp_err;
    logic                   w_acc;
    logic                   w_wr_ok;
    logic [OP_W-1:0]        w_cmd_op;
    logic                   w_launch;
    logic                   w_complete;
    logic                   w_timeout;
    logic [DATA_W-1:0]      w_stat_word;
    logic [DATA_W-1:0]      w_rd_word;
    logic [VW*DATA_W-1:0]   w_value_nxt;
    logic [KW*DATA_W-1:0]   w_key_nxt;

    generate
        if (AL > 0) begin : g_unused_addr
            logic w_unused_addr;
            assign w_unused_addr = ^obi_addr_i[AL-1:0];
        end
    endgenerate

    assign w_widx     = obi_addr_i[ADDR_W-1:AL];
    assign w_busy     = (r_state == C_BUSY);
    assign w_sel_val  = (w_widx < A_KEY);
    assign w_sel_key  = (w_widx >= A_KEY) && (w_widx < A_CMD);
    assign w_sel_cmd  = (w_widx == A_CMD);
    assign w_sel_stat = (w_widx == A_STAT);
    assign w_sel_res  = (w_widx >= A_RES) && (w_widx < A_END);
    assign w_mapped   = w_sel_val | w_sel_key | w_sel_cmd | w_sel_stat | w_sel_res;

    // Operands are frozen while an operation is in flight; RESULT is read-only.
    assign w_rsp_err  = !w_mapped ||
                        (obi_we_i && (w_sel_res || (w_busy && (w_sel_val || w_sel_key || w_sel_cmd))));

    assign obi_gnt_o  = !r_rvalid || obi_rready_i;
    assign w_acc      = obi_req_i && obi_gnt_o;
    assign w_wr_ok    = w_acc && obi_we_i && !w_rsp_err;
    assign w_cmd_op   = obi_wdata_i[OP_W-1:0];
    assign w_launch   = w_wr_ok && w_sel_cmd && (w_cmd_op != '0);

    assign w_stat_word = DATA_W'({r_tmo, r_err, r_done, w_busy});

    always_comb begin
        w_value_nxt = r_value;
        w_key_nxt   = r_key;
        w_rd_word   = '0;
        for (int w = 0; w < VW; w++) begin
            if (w_widx == WI'(w)) begin
                w_rd_word = r_value[w*DATA_W +: DATA_W];
                for (int b = 0; b < BE_W; b++) begin
                    if (obi_be_i[b]) w_value_nxt[w*DATA_W + b*8 +: 8] = obi_wdata_i[b*8 +: 8];
                end
            end
            if (w_widx == A_RES + WI'(w)) w_rd_word = r_result[w*DATA_W +: DATA_W];
        end
        for (int w = 0; w < KW; w++) begin
            if (w_widx == A_KEY + WI'(w)) begin
                w_rd_word = r_key[w*DATA_W +: DATA_W];
                for (int b = 0; b < BE_W; b++) begin
                    if (obi_be_i[b]) w_key_nxt[w*DATA_W + b*8 +: 8] = obi_wdata_i[b*8 +: 8];
                end
            end
        end
        if (w_sel_stat) w_rd_word = w_stat_word;
        if (obi_we_i || w_rsp_err) w_rd_word = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= C_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A completion pulse in the same cycle as the last timeout count takes priority.
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        op_o        = '0;
        case (r_state)
            C_IDLE: begin
                if (w_launch) w_state_nxt = C_BUSY;
            end
            C_BUSY: begin
                op_o = r_op;
                if (ctrl_ready_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = C_IDLE;
                end else if ((TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1))) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = C_IDLE;
                end
            end
            default: w_state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= '0;
            r_cnt <= '0;
        end else if (w_launch) begin
            r_op  <= w_cmd_op;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Completion/timeout set the sticky bits after any same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_tmo  <= 1'b0;
        end else if (w_launch) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_tmo  <= 1'b0;
        end else if (w_complete) begin
            r_done <= 1'b1;
            r_err  <= !ctrl_succ_i;
        end else if (w_timeout) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
            r_tmo  <= 1'b1;
        end else if (w_wr_ok && w_sel_stat && obi_be_i[0]) begin
            r_done <= r_done && !obi_wdata_i[1];
            r_err  <= r_err  && !obi_wdata_i[2];
            r_tmo  <= r_tmo  && !obi_wdata_i[3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value  <= '0;
            r_key    <= '0;
            r_result <= '0;
        end else begin
            if (w_wr_ok && w_sel_val) r_value <= w_value_nxt & VMASK;
            if (w_wr_ok && w_sel_key) r_key   <= w_key_nxt & KMASK;
            if (w_complete)           r_result <= (VW*DATA_W)'(ctrl_value_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rerr   <= 1'b0;
        end else if (w_acc) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word;
            r_rerr   <= w_rsp_err;
        end else if (obi_rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

    assign obi_rvalid_o = r_rvalid;
    assign obi_rdata_o  = r_rdata;
    assign obi_err_o    = r_rerr;
    assign key_o        = r_key[KEY_W-1:0];
    assign value_o      = r_value[VALUE_W-1:0];
    assign done_o       = r_done;

endmodule

// File: tb/tb_obi_cache_regif.sv
// Bench for obi_cache_regif: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_obi_cache_regif;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [7:0]  obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
    logic        obi_rready_i;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [1:0]  op_o;
    logic [31:0] key_o;
    logic [63:0] value_o;
    logic        ctrl_ready_i;
    logic        ctrl_succ_i;
    logic [63:0] ctrl_value_i;
    logic        done_o;

    obi_cache_regif #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rready_i(obi_rready_i),
        .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .op_o(op_o), .key_o(key_o), .value_o(value_o),
        .ctrl_ready_i(ctrl_ready_i), .ctrl_succ_i(ctrl_succ_i),
        .ctrl_value_i(ctrl_value_i), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_run = 0;
    int last_run = 0;

    // Reference model: register words and controller state.
    logic [31:0] m_val [2] = '{32'h0, 32'h0};
    logic [31:0] m_key = 32'h0;
    logic [31:0] m_res [2] = '{32'h0, 32'h0};
    logic [1:0]  m_op = 2'd0;
    logic [31:0] m_rdata = 32'h0;
    bit          m_busy = 0, m_done = 0, m_err = 0, m_tmo = 0, m_rv = 0, m_rerr = 0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic model_step();
        bit          was_busy, acc, e;
        int          w;
        logic [31:0] rd;
        if (rst) begin
            m_val = '{32'h0, 32'h0}; m_key = 0; m_res = '{32'h0, 32'h0};
            m_op = 0; m_rdata = 0; m_busy = 0; m_done = 0; m_err = 0; m_tmo = 0;
            m_rv = 0; m_rerr = 0; m_cnt = 0;
            return;
        end
        was_busy = m_busy;
        acc = obi_req_i && (!m_rv || obi_rready_i);
        if (m_rv && obi_rready_i) m_rv = 0;
        if (acc) begin
            w  = int'(obi_addr_i[7:2]);
            e  = 0;
            rd = 0;
            if (obi_we_i) begin
                if (w <= 2) begin
                    if (was_busy) e = 1;
                    else if (w < 2) m_val[w] = merge(m_val[w], obi_be_i, obi_wdata_i);
                    else m_key = merge(m_key, obi_be_i, obi_wdata_i);
                end else if (w == 3) begin
                    if (was_busy) e = 1;
                    else if (obi_wdata_i[1:0] != 0) begin
                        m_op = obi_wdata_i[1:0]; m_busy = 1; m_cnt = 0;
                        m_done = 0; m_err = 0; m_tmo = 0;
                    end
                end else if (w == 4) begin
                    if (obi_be_i[0]) begin
                        if (obi_wdata_i[1]) m_done = 0;
                        if (obi_wdata_i[2]) m_err = 0;
                        if (obi_wdata_i[3]) m_tmo = 0;
                    end
                end else e = 1;
            end else begin
                if (w < 2)       rd = m_val[w];
                else if (w == 2) rd = m_key;
                else if (w == 3) rd = 0;
                else if (w == 4) rd = {28'h0, m_tmo, m_err, m_done, was_busy};
                else if (w < 7)  rd = m_res[w-5];
                else e = 1;
            end
            m_rv = 1; m_rdata = rd; m_rerr = e;
        end
        if (was_busy) begin
            if (ctrl_ready_i) begin
                m_res[0] = ctrl_value_i[31:0]; m_res[1] = ctrl_value_i[63:32];
                m_err = !ctrl_succ_i; m_done = 1; m_busy = 0;
            end else if (m_cnt == TO - 1) begin
                m_done = 1; m_err = 1; m_tmo = 1; m_busy = 0;
            end else m_cnt++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("gnt", 64'(obi_gnt_o), 64'(!m_rv || obi_rready_i));
        chk("rvalid", 64'(obi_rvalid_o), 64'(m_rv));
        if (m_rv) begin
            chk("rdata", 64'(obi_rdata_o), 64'(m_rdata));
            chk("rerr", 64'(obi_err_o), 64'(m_rerr));
        end
        chk("op", 64'(op_o), m_busy ? 64'(m_op) : 64'(0));
        chk("key", 64'(key_o), 64'(m_key));
        chk("value", value_o, {m_val[1], m_val[0]});
        chk("done", 64'(done_o), 64'(m_done));
        if (op_o != 0) cur_run++;
        else begin
            if (cur_run != 0) last_run = cur_run;
            cur_run = 0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 64'(obi_gnt_o), 64'(1));
        chk({tag, "_rvalid"}, 64'(obi_rvalid_o), 64'(0));
        chk({tag, "_rdata"}, 64'(obi_rdata_o), 64'(0));
        chk({tag, "_err"}, 64'(obi_err_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
        chk({tag, "_op"}, 64'(op_o), 64'(0));
        chk({tag, "_key"}, 64'(key_o), 64'(0));
        chk({tag, "_value"}, value_o, 64'(0));
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xfer(input logic we, input int word, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n = 0;
        obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = 8'(word * 4);
        obi_be_i = be; obi_wdata_i = wd; obi_rready_i = 1'b1;
        @(negedge clk);
        while (!obi_gnt_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL gnt_wait: got gnt=0 for 50 cycles, expected a grant");
        end
        @(posedge clk); #1;
        obi_req_i = 1'b0; obi_we_i = 1'b0;
        @(negedge clk);
        chk("xfer_rvalid_latency", 64'(obi_rvalid_o), 64'(1));
        rd = obi_rdata_o;
        er = obi_err_o;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        er;
    int          word;

    initial begin
        rst = 1'b1;
        obi_req_i = 0; obi_we_i = 0; obi_addr_i = 0; obi_be_i = 0; obi_wdata_i = 0;
        obi_rready_i = 1; ctrl_ready_i = 0; ctrl_succ_i = 0; ctrl_value_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Operand staging, launch and successful completion.
        xfer(1, 0, 4'hF, 32'h1111_2222, rd, er);
        xfer(1, 1, 4'hF, 32'h3333_4444, rd, er);
        xfer(1, 2, 4'hF, 32'h0000_ABCD, rd, er);
        chk("t1_value_o", value_o, 64'h3333_4444_1111_2222);
        chk("t1_key_o", 64'(key_o), 64'h0000_ABCD);
        ctrl_value_i = 64'h5555_5555_6666_6666; ctrl_succ_i = 1;
        xfer(1, 3, 4'hF, 32'h1, rd, er);
        chk("t1_op_busy", 64'(op_o), 64'd1);
        ctrl_ready_i = 1;
        @(posedge clk); #1;
        ctrl_ready_i = 0;
        xfer(0, 4, 4'h0, 0, rd, er);
        chk("t1_status", 64'(rd), 64'h2);
        chk("t1_busy_cycles", 64'(last_run), 64'd2);
        xfer(0, 5, 4'h0, 0, rd, er);
        chk("t1_result_lo", 64'(rd), 64'h6666_6666);
        xfer(0, 6, 4'h0, 0, rd, er);
        chk("t1_result_hi", 64'(rd), 64'h5555_5555);
        chk("t1_done_o", 64'(done_o), 64'd1);

        // Back-to-back reads with a stalled response channel.
        obi_req_i = 1; obi_we_i = 0; obi_addr_i = 8'd8; obi_rready_i = 0;
        @(negedge clk);
        chk("t2_gnt_idle", 64'(obi_gnt_o), 64'd1);
        @(posedge clk); #1;
        obi_addr_i = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_gnt_stall", 64'(obi_gnt_o), 64'd0);
            chk("t2_rdata_hold", 64'(obi_rdata_o), 64'h0000_ABCD);
            @(posedge clk); #1;
        end
        obi_rready_i = 1;
        @(negedge clk);
        chk("t2_gnt_release", 64'(obi_gnt_o), 64'd1);
        @(posedge clk); #1;
        obi_req_i = 0;
        @(negedge clk);
        chk("t2_second_rvalid", 64'(obi_rvalid_o), 64'd1);
        chk("t2_second_rdata", 64'(obi_rdata_o), 64'h1111_2222);
        @(posedge clk); #1;

        // Busy rejections; the completion lands on the last timeout count and must win.
        ctrl_value_i = 64'hDEAD_BEEF_0000_0001; ctrl_succ_i = 1;
        xfer(1, 3, 4'hF, 32'h1, rd, er);
        xfer(1, 3, 4'hF, 32'h2, rd, er);
        chk("t3_cmd_busy_err", 64'(er), 64'd1);
        xfer(1, 2, 4'hF, 32'h1234, rd, er);
        chk("t3_key_busy_err", 64'(er), 64'd1);
        chk("t3_key_frozen", 64'(key_o), 64'h0000_ABCD);
        xfer(0, 7, 4'h0, 0, rd, er);
        chk("t3_unmapped_err", 64'(er), 64'd1);
        chk("t3_unmapped_rdata", 64'(rd), 64'd0);
        chk("t3_op_held", 64'(op_o), 64'd1);
        ctrl_ready_i = 1;
        @(posedge clk); #1;
        ctrl_ready_i = 0;
        xfer(0, 4, 4'h0, 0, rd, er);
        chk("t3_ready_beats_timeout", 64'(rd), 64'h2);
        xfer(0, 6, 4'h0, 0, rd, er);
        chk("t3_result_hi", 64'(rd), 64'hDEAD_BEEF);

        // Timeout without a ready pulse, then write-1-to-clear.
        xfer(1, 3, 4'hF, 32'h2, rd, er);
        repeat (12) @(posedge clk);
        #1;
        chk("t4_busy_cycles", 64'(last_run), 64'd8);
        xfer(0, 4, 4'h0, 0, rd, er);
        chk("t4_status_timeout", 64'(rd), 64'hE);
        chk("t4_done_o", 64'(done_o), 64'd1);
        xfer(1, 4, 4'hF, 32'hE, rd, er);
        chk("t4_w1c_err", 64'(er), 64'd0);
        xfer(0, 4, 4'h0, 0, rd, er);
        chk("t4_status_cleared", 64'(rd), 64'h0);
        chk("t4_done_cleared", 64'(done_o), 64'd0);

        // Partial byte-enable write to KEY.
        xfer(1, 2, 4'b0010, 32'hFFFF_FFFF, rd, er);
        chk("t5_key_byte1", 64'(key_o), 64'h0000_FFCD);

        // Asynchronous reset while busy with a response pending.
        xfer(1, 3, 4'hF, 32'h3, rd, er);
        obi_req_i = 1; obi_we_i = 0; obi_addr_i = 8'd0; obi_rready_i = 0;
        @(posedge clk); #1;
        obi_req_i = 0;
        #2;
        rst = 1;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk); #1;
        rst = 0; obi_rready_i = 1;
        xfer(1, 3, 4'hF, 32'h1, rd, er);
        chk("t6_cmd_after_reset_err", 64'(er), 64'd0);
        chk("t6_cmd_after_reset_op", 64'(op_o), 64'd1);
        repeat (12) @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            word = int'($urandom_range(0, 15));
            if (word >= 10) word = int'($urandom_range(0, 63));
            obi_req_i    = ($urandom_range(0, 2) != 0);
            obi_we_i     = 1'($urandom);
            obi_addr_i   = 8'(word * 4) | 8'($urandom_range(0, 3));
            obi_be_i     = 4'($urandom);
            obi_wdata_i  = $urandom;
            obi_rready_i = ($urandom_range(0, 3) != 0);
            ctrl_ready_i = ($urandom_range(0, 5) == 0);
            ctrl_succ_i  = 1'($urandom);
            ctrl_value_i = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        obi_req_i = 0; obi_rready_i = 1; ctrl_ready_i = 0;
        repeat (20) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
